// File: rtl/cursor_overlay_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_pkg
//  Description : Shared types and defaults for the cursor overlay pipeline:
//                committed cursor modes, per-pixel sprite codes and the
//                default outline/fill colours.
//  Revision    : 1.0  initial release
// ============================================================================
package cursor_pkg;

    typedef enum logic [1:0] {
        MODE_ARROW  = 2'd0,
        MODE_SCOPE  = 2'd1,
        MODE_HIDDEN = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        PIX_TRANSP = 2'd0,
        PIX_EDGE   = 2'd1,
        PIX_FILL   = 2'd2
    } pix_code_t;

    localparam logic [11:0] C_DEF_COL_EDGE = 12'h000;
    localparam logic [11:0] C_DEF_COL_FILL = 12'hFFF;

endpackage
`default_nettype wire

// File: rtl/cursor_overlay_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_overlay_pipe_if
//  Description : VGA pixel-stream bundle (counters, sync, blanking, colour).
//                master = producer of the stream, slave = consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface cursor_overlay_pipe_if #(
    parameter int RGB_W = 12
);
    logic [10:0]      hcount;
    logic [9:0]       vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/cursor_overlay_pipe_arrow_rom.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_arrow_rom
//  Description : Combinational arrow-sprite lookup. Returns the pixel code
//                (transparent / outline / fill) for sprite coordinate (x,y),
//                hotspot at the top-left corner.
//  Ports       : i_x, i_y  sprite column / row
//                o_code    pixel code
//  Revision    : 1.0  initial release
// ============================================================================
module cursor_arrow_rom
    import cursor_pkg::*;
#(
    parameter int ARROW_W = 12,
    parameter int ARROW_H = 18,
    parameter int XW      = $clog2(ARROW_W),
    parameter int YW      = $clog2(ARROW_H)
) (
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output pix_code_t     o_code
);

    // Art is stored as text rows: 'X' outline, 'o' fill, '.' transparent.
    localparam int C_ART_W = 12;
    localparam int C_ART_H = 18;
    localparam logic [C_ART_W*8-1:0] C_ART [C_ART_H] = '{
        "X...........",
        "XX..........",
        "XoX.........",
        "XooX........",
        "XoooX.......",
        "XooooX......",
        "XoooooX.....",
        "XooooooX....",
        "XoooooooX...",
        "XooooooooX..",
        "XoooooooooX.",
        "XooooooXXXXX",
        "XoooXooX....",
        "XooX.XooX...",
        "XoX..XooX...",
        "XX....XooX..",
        "X.....XooX..",
        ".......XX..."
    };

    logic [C_ART_W*8-1:0] w_row;
    logic [7:0]           w_chr;

    always_comb begin
        w_row = '0;
        w_chr = 8'h2E;
        for (int r = 0; r < C_ART_H; r++) begin
            if (32'(i_y) == r) w_row = C_ART[r];
        end
        for (int c = 0; c < C_ART_W; c++) begin
            if (32'(i_x) == c) w_chr = w_row[(C_ART_W-1-c)*8 +: 8];
        end
        // Sprite sizes beyond the stored art read as transparent.
        if (32'(i_x) >= ARROW_W || 32'(i_y) >= ARROW_H) w_chr = 8'h2E;
        o_code = PIX_TRANSP;
        if (w_chr == "X")      o_code = PIX_EDGE;
        else if (w_chr == "o") o_code = PIX_FILL;
    end

endmodule
`default_nettype wire

// File: rtl/cursor_overlay_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_overlay_pipe
//  Description : Mouse-cursor overlay stage of the VGA pipeline. Draws an
//                arrow, a scope crosshair or nothing at the cursor position
//                latched at frame start. Fixed 2-cycle latency on all outputs.
//  Ports       : clk, rst_n          pixel clock, async active-low reset
//                i_xpos, i_ypos      cursor position (clk domain)
//                i_scope_req         request crosshair mode
//                i_hide_req          request hidden cursor (wins over scope)
//                i_vid               upstream pixel stream
//                o_vid               overlaid pixel stream, delayed 2 clk
//                o_mode              committed mode
//  Revision    : 1.0  initial release
// ============================================================================
module cursor_overlay_pipe
    import cursor_pkg::*;
#(
    parameter int               RGB_W      = 12,
    parameter int               ARROW_W    = 12,
    parameter int               ARROW_H    = 18,
    parameter int               SCOPE_ARM  = 4,
    parameter int               SCOPE_GAP  = 1,
    parameter int               SCOPE_XLIM = 768,
    parameter logic [RGB_W-1:0] COL_EDGE   = C_DEF_COL_EDGE,
    parameter logic [RGB_W-1:0] COL_FILL   = C_DEF_COL_FILL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [11:0]            i_xpos,
    input  logic [11:0]            i_ypos,
    input  logic                   i_scope_req,
    input  logic                   i_hide_req,
    cursor_overlay_pipe_if.slave   i_vid,
    cursor_overlay_pipe_if.master  o_vid,
    output logic [1:0]             o_mode
);

    localparam int C_AXW = $clog2(ARROW_W);
    localparam int C_AYW = $clog2(ARROW_H);

    // ---------------- frame-start commit ----------------
    mode_t       r_mode;
    logic [11:0] r_x_lat;
    logic [11:0] r_y_lat;
    logic        r_vsync_d;
    logic        w_frame_start;

    assign w_frame_start = i_vid.vsync & ~r_vsync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_ARROW;
            r_x_lat   <= '0;
            r_y_lat   <= '0;
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= i_vid.vsync;
            if (w_frame_start) begin
                r_x_lat <= i_xpos;
                r_y_lat <= i_ypos;
                if (i_hide_req)
                    r_mode <= MODE_HIDDEN;
                else if (i_scope_req && (32'(i_xpos) < SCOPE_XLIM))
                    r_mode <= MODE_SCOPE;
                else
                    r_mode <= MODE_ARROW;
            end
        end
    end

    assign o_mode = r_mode;

    // ---------------- stage 1 / stage 2 registers ----------------
    // Offsets are 13-bit two's complement so a cursor far right/bottom never
    // wraps back onto low screen coordinates.
    logic [12:0]      r_dx;
    logic [12:0]      r_dy;
    logic [RGB_W-1:0] r_rgb_d1;
    logic [10:0]      r_hcnt_d1;
    logic [9:0]       r_vcnt_d1;
    logic             r_hs_d1, r_vs_d1, r_hb_d1, r_vb_d1;

    pix_code_t        w_rom_code;
    pix_code_t        w_code;
    logic [12:0]      w_adx;
    logic [12:0]      w_ady;
    logic             w_dx_zero, w_dy_zero, w_adx_arm, w_ady_arm;
    logic [RGB_W-1:0] w_rgb_px;

    cursor_arrow_rom #(
        .ARROW_W (ARROW_W),
        .ARROW_H (ARROW_H)
    ) u_rom (
        .i_x    (r_dx[C_AXW-1:0]),
        .i_y    (r_dy[C_AYW-1:0]),
        .o_code (w_rom_code)
    );

    always_comb begin
        w_adx     = r_dx[12] ? (13'd0 - r_dx) : r_dx;
        w_ady     = r_dy[12] ? (13'd0 - r_dy) : r_dy;
        w_dx_zero = (r_dx == 13'd0);
        w_dy_zero = (r_dy == 13'd0);
        w_adx_arm = (32'(w_adx) > SCOPE_GAP) && (32'(w_adx) <= SCOPE_ARM);
        w_ady_arm = (32'(w_ady) > SCOPE_GAP) && (32'(w_ady) <= SCOPE_ARM);
        w_code    = PIX_TRANSP;
        case (r_mode)
            MODE_ARROW: begin
                if (!r_dx[12] && (32'(r_dx[11:0]) < ARROW_W) &&
                    !r_dy[12] && (32'(r_dy[11:0]) < ARROW_H))
                    w_code = w_rom_code;
            end
            MODE_SCOPE: begin
                if ((w_dx_zero && w_dy_zero) || (w_dy_zero && w_adx_arm) ||
                    (w_dx_zero && w_ady_arm))
                    w_code = PIX_EDGE;
            end
            default: w_code = PIX_TRANSP;
        endcase
        w_rgb_px = r_rgb_d1;
        if (!(r_hb_d1 | r_vb_d1)) begin
            if (w_code == PIX_EDGE)      w_rgb_px = COL_EDGE;
            else if (w_code == PIX_FILL) w_rgb_px = COL_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dx         <= '0;
            r_dy         <= '0;
            r_rgb_d1     <= '0;
            r_hcnt_d1    <= '0;
            r_vcnt_d1    <= '0;
            r_hs_d1      <= 1'b0;
            r_vs_d1      <= 1'b0;
            r_hb_d1      <= 1'b0;
            r_vb_d1      <= 1'b0;
            o_vid.hcount <= '0;
            o_vid.vcount <= '0;
            o_vid.hsync  <= 1'b0;
            o_vid.vsync  <= 1'b0;
            o_vid.hblnk  <= 1'b0;
            o_vid.vblnk  <= 1'b0;
            o_vid.rgb    <= '0;
        end else begin
            r_dx         <= {2'b00, i_vid.hcount} - {1'b0, r_x_lat};
            r_dy         <= {3'b000, i_vid.vcount} - {1'b0, r_y_lat};
            r_rgb_d1     <= i_vid.rgb;
            r_hcnt_d1    <= i_vid.hcount;
            r_vcnt_d1    <= i_vid.vcount;
            r_hs_d1      <= i_vid.hsync;
            r_vs_d1      <= i_vid.vsync;
            r_hb_d1      <= i_vid.hblnk;
            r_vb_d1      <= i_vid.vblnk;
            o_vid.hcount <= r_hcnt_d1;
            o_vid.vcount <= r_vcnt_d1;
            o_vid.hsync  <= r_hs_d1;
            o_vid.vsync  <= r_vs_d1;
            o_vid.hblnk  <= r_hb_d1;
            o_vid.vblnk  <= r_vb_d1;
            o_vid.rgb    <= w_rgb_px;
        end
    end

endmodule
`default_nettype wire
